// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the pending-interrupt controller.
package irq_pkg;

    localparam int NUM_CH = 4;
    localparam int ID_W   = 2;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2
    } irq_state_t;

endpackage

// File: rtl/req_capture.sv
// Request capture: registers raw requests and maintains the pending and overrun vectors.
// IRQ_EDGE_EN selects rising-edge capture with overrun detection; otherwise level capture.
module req_capture
    import irq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] clr,
    input  logic              clr_ovf,
    output logic [NUM_CH-1:0] pend,
    output logic [NUM_CH-1:0] ovf
);

    logic [NUM_CH-1:0] set_ev;
    logic [NUM_CH-1:0] ovf_set;

`ifdef IRQ_EDGE_EN
    logic [NUM_CH-1:0] req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else begin
            req_q <= req;
        end
    end

    assign set_ev  = req & ~req_q;
    // A fresh edge on an already-pending channel that is not being served is lost.
    assign ovf_set = set_ev & pend & ~clr;
`else
    assign set_ev  = req;
    assign ovf_set = '0;
`endif

    // Set wins over clear; a new overrun wins over clr_ovf.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            ovf  <= '0;
        end else begin
            pend <= set_ev | (pend & ~clr);
            ovf  <= ovf_set | (clr_ovf ? '0 : ovf);
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Pending-request hand-off stage around an external 4-to-2 priority encoder.
// Optional macro IRQ_EDGE_EN switches request capture from level to rising edge.
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] pend,
    input  logic [ID_W-1:0]   enc_b,
    input  logic              enc_v,
    output logic              irq_valid,
    output logic [ID_W-1:0]   irq_id,
    input  logic              irq_ready,
    output logic [NUM_CH-1:0] ovf,
    input  logic              clr_ovf,
    output logic              timeout
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    // Handshake: an offer (irq_valid=1) holds irq_id stable until irq_ready is seen
    // high on a rising edge; that edge is the accept and the offer drops the next cycle.
    irq_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ID_W-1:0]   id_q, id_nxt;
    logic              accept;
    logic [NUM_CH-1:0] clr_vec;

    req_capture u_req_capture (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .clr     (clr_vec),
        .clr_ovf (clr_ovf),
        .pend    (pend),
        .ovf     (ovf)
    );

    assign clr_vec = accept ? (NUM_CH'(1) << id_q) : '0;
    assign irq_id  = id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            id_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            id_q  <= id_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        id_nxt    = id_q;
        irq_valid = 1'b0;
        timeout   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (enc_v) begin
                    id_nxt    = enc_b;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                irq_valid = 1'b1;
                if (irq_ready) begin
                    accept    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = GAP;
                end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
                    // Withdraw without touching pend so the channel is offered again.
                    timeout   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = GAP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl with a behavioural priority encoder closing the loop.
module tb_irq_pending_ctrl;

    localparam int TO = 4;
`ifdef IRQ_EDGE_EN
    localparam logic EDGE = 1'b1;
`else
    localparam logic EDGE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic       irq_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [1:0] enc_b;
    logic       enc_v;
    logic [3:0] pend;
    logic       irq_valid;
    logic [1:0] irq_id;
    logic [3:0] ovf;
    logic       timeout;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    // Environment model of the 4-to-2 priority encoder (bit 3 highest).
    always_comb begin
        enc_v = |pend;
        if (pend[3])      enc_b = 2'd3;
        else if (pend[2]) enc_b = 2'd2;
        else if (pend[1]) enc_b = 2'd1;
        else              enc_b = 2'd0;
    end

    irq_pending_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .pend      (pend),
        .enc_b     (enc_b),
        .enc_v     (enc_v),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .irq_ready (irq_ready),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf),
        .timeout   (timeout)
    );

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_offer(input int budget);
        int waited;
        waited = 0;
        while (!irq_valid && waited < budget) begin
            tick();
            waited++;
        end
    endtask

    function automatic logic [1:0] pop_exp();
        if (exp_q.size() == 0) return 2'bxx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (pend !== 4'b0) $display("FAIL reset_pend: got %b want 0000", pend); else passes++;
        checks++; if (irq_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", irq_valid); else passes++;
        checks++; if (irq_id !== 2'd0) $display("FAIL reset_id: got %0d want 0", irq_id); else passes++;
        checks++; if (ovf !== 4'b0) $display("FAIL reset_ovf: got %b want 0000", ovf); else passes++;
        checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else passes++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int start;
        logic [1:0] e;
        irq_ready = 1'b1;
        req = 4'b0100;
        exp_q.push_back(2'd2);
        start = cyc;
        tick();
        req = 4'b0;
        checks++; if (pend !== 4'b0100) $display("FAIL single_pend_set: got %b want 0100", pend); else passes++;
        checks++; if (irq_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", irq_valid); else passes++;
        wait_offer(10);
        checks++; if (irq_valid !== 1'b1) $display("FAIL single_offer: got %b want 1", irq_valid); else passes++;
        checks++; if (cyc - start !== 2) $display("FAIL single_latency: got %0d want 2", cyc - start); else passes++;
        e = pop_exp();
        checks++; if (irq_id !== e) $display("FAIL single_id: got %0d want %0d", irq_id, e); else passes++;
        tick();
        checks++; if (pend !== 4'b0) $display("FAIL single_pend_clr: got %b want 0000", pend); else passes++;
        checks++; if (irq_valid !== 1'b0) $display("FAIL single_gap: got %b want 0", irq_valid); else passes++;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        int last;
        logic [1:0] e;
        last = 0;
        irq_ready = 1'b1;
        req = 4'b1011;
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        tick();
        req = 4'b0;
        for (int k = 0; k < 3; k++) begin
            wait_offer(10);
            checks++; if (irq_valid !== 1'b1) $display("FAIL b2b_offer%0d: got %b want 1", k, irq_valid); else passes++;
            e = pop_exp();
            checks++; if (irq_id !== e) $display("FAIL b2b_id%0d: got %0d want %0d", k, irq_id, e); else passes++;
            if (k > 0) begin
                checks++; if (cyc - last !== 3) $display("FAIL b2b_spacing%0d: got %0d want 3", k, cyc - last); else passes++;
            end
            last = cyc;
            tick();
        end
        checks++; if (pend !== 4'b0) $display("FAIL b2b_pend_empty: got %b want 0000", pend); else passes++;
        tick();
        tick();
    endtask

    task automatic test_no_preempt();
        logic [1:0] e;
        irq_ready = 1'b0;
        req = 4'b0010;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        tick();
        req = 4'b0;
        wait_offer(10);
        e = pop_exp();
        checks++; if (irq_id !== e) $display("FAIL nopre_first_id: got %0d want %0d", irq_id, e); else passes++;
        req = 4'b1000;
        tick();
        req = 4'b0;
        checks++; if (irq_id !== e || irq_valid !== 1'b1) $display("FAIL nopre_hold1: got v=%b id=%0d want v=1 id=%0d", irq_valid, irq_id, e); else passes++;
        tick();
        checks++; if (irq_id !== e || irq_valid !== 1'b1) $display("FAIL nopre_hold2: got v=%b id=%0d want v=1 id=%0d", irq_valid, irq_id, e); else passes++;
        checks++; if (pend !== 4'b1010) $display("FAIL nopre_pend: got %b want 1010", pend); else passes++;
        irq_ready = 1'b1;
        tick();
        checks++; if (pend !== 4'b1000) $display("FAIL nopre_pend_after: got %b want 1000", pend); else passes++;
        wait_offer(10);
        e = pop_exp();
        checks++; if (irq_id !== e || irq_valid !== 1'b1) $display("FAIL nopre_next_id: got v=%b id=%0d want v=1 id=%0d", irq_valid, irq_id, e); else passes++;
        tick();
        checks++; if (pend !== 4'b0) $display("FAIL nopre_pend_empty: got %b want 0000", pend); else passes++;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        logic [1:0] e;
        irq_ready = 1'b0;
        req = 4'b0001;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        tick();
        req = 4'b0;
        wait_offer(10);
        e = pop_exp();
        checks++; if (irq_id !== e || irq_valid !== 1'b1) $display("FAIL to_offer: got v=%b id=%0d want v=1 id=%0d", irq_valid, irq_id, e); else passes++;
        checks++; if (timeout !== 1'b0) $display("FAIL to_early1: got %b want 0", timeout); else passes++;
        tick();
        tick();
        checks++; if (timeout !== 1'b0) $display("FAIL to_early3: got %b want 0", timeout); else passes++;
        tick();
        checks++; if (timeout !== 1'b1) $display("FAIL to_pulse: got %b want 1", timeout); else passes++;
        checks++; if (irq_valid !== 1'b1) $display("FAIL to_valid4: got %b want 1", irq_valid); else passes++;
        tick();
        checks++; if (irq_valid !== 1'b0 || timeout !== 1'b0) $display("FAIL to_gap: got v=%b to=%b want v=0 to=0", irq_valid, timeout); else passes++;
        checks++; if (pend !== 4'b0001) $display("FAIL to_pend_kept: got %b want 0001", pend); else passes++;
        irq_ready = 1'b1;
        wait_offer(10);
        e = pop_exp();
        checks++; if (irq_id !== e || irq_valid !== 1'b1) $display("FAIL to_reoffer: got v=%b id=%0d want v=1 id=%0d", irq_valid, irq_id, e); else passes++;
        tick();
        checks++; if (pend !== 4'b0) $display("FAIL to_pend_clr: got %b want 0000", pend); else passes++;
        tick();
        tick();
    endtask

    task automatic test_ovf();
        logic [1:0] e;
        logic [3:0] exp_ovf;
        exp_ovf = EDGE ? 4'b0001 : 4'b0000;
        irq_ready = 1'b0;
        req = 4'b0001;
        exp_q.push_back(2'd0);
        tick();
        req = 4'b0;
        tick();
        checks++; if (irq_valid !== 1'b1) $display("FAIL ovf_offer: got %b want 1", irq_valid); else passes++;
        req = 4'b0001;
        tick();
        req = 4'b0;
        checks++; if (ovf !== exp_ovf) $display("FAIL ovf_set: got %b want %b", ovf, exp_ovf); else passes++;
        e = pop_exp();
        checks++; if (irq_id !== e) $display("FAIL ovf_id: got %0d want %0d", irq_id, e); else passes++;
        irq_ready = 1'b1;
        tick();
        checks++; if (pend !== 4'b0) $display("FAIL ovf_pend_clr: got %b want 0000", pend); else passes++;
        checks++; if (ovf !== exp_ovf) $display("FAIL ovf_sticky: got %b want %b", ovf, exp_ovf); else passes++;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++; if (ovf !== 4'b0) $display("FAIL ovf_clear: got %b want 0000", ovf); else passes++;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int start;
        logic [1:0] e;
        irq_ready = 1'b0;
        req = 4'b0100;
        exp_q.push_back(2'd2);
        tick();
        req = 4'b0;
        wait_offer(10);
        e = pop_exp();
        checks++; if (irq_id !== e || irq_valid !== 1'b1) $display("FAIL rmid_offer: got v=%b id=%0d want v=1 id=%0d", irq_valid, irq_id, e); else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (irq_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", irq_valid); else passes++;
        checks++; if (pend !== 4'b0) $display("FAIL rmid_pend: got %b want 0000", pend); else passes++;
        checks++; if (ovf !== 4'b0) $display("FAIL rmid_ovf: got %b want 0000", ovf); else passes++;
        checks++; if (irq_id !== 2'd0) $display("FAIL rmid_id: got %0d want 0", irq_id); else passes++;
        tick();
        tick();
        rst_n = 1'b1;
        irq_ready = 1'b1;
        req = 4'b0010;
        exp_q.push_back(2'd1);
        start = cyc;
        tick();
        req = 4'b0;
        wait_offer(10);
        checks++; if (cyc - start !== 2) $display("FAIL rmid_latency: got %0d want 2", cyc - start); else passes++;
        e = pop_exp();
        checks++; if (irq_id !== e || irq_valid !== 1'b1) $display("FAIL rmid_restart_id: got v=%b id=%0d want v=1 id=%0d", irq_valid, irq_id, e); else passes++;
        tick();
        checks++; if (pend !== 4'b0) $display("FAIL rmid_pend_clr: got %b want 0000", pend); else passes++;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_no_preempt();
        test_timeout();
        test_ovf();
        test_reset_mid();
        checks++; if (exp_q.size() !== 0) $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/irq_pending_ctrl.md
# irq_pending_ctrl

Four-channel request capture and hand-off stage wrapped around the 4-to-2 priority encoder. It latches incoming requests into a pending vector that drives the encoder's `a` input. It reads back the encoder's index `b` and valid `v`, and offers the winning index downstream over a valid/ready handshake. On acceptance it clears the served pending bit so the encoder moves to the next-highest request.

## Interface
- `TIMEOUT`, default 15: OFFER cycles without `irq_ready` before the offer is withdrawn; 0 disables the timeout.
- `clk`  in  1  rising-edge clock, sole clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  4  raw request lines, synchronous to `clk`; bit 3 is highest priority
- `pend`  out  4  pending vector; connects to encoder `a`
- `enc_b`  in  2  encoder index `b`
- `enc_v`  in  1  encoder valid `v`
- `irq_valid`  out  1  offer valid
- `irq_id`  out  2  offered channel index
- `irq_ready`  in  1  downstream accept
- `ovf`  out  4  sticky per-channel overrun flags
- `clr_ovf`  in  1  synchronous clear of all `ovf` bits
- `timeout`  out  1  one-cycle pulse when an offer is withdrawn

## Operation
- `req_q` holds `req` registered every cycle.
- Set event for channel i:
  - IRQ_EDGE_EN defined: `req[i] & ~req_q[i]`.
  - Otherwise: `req[i]`.
- Clear event for channel i: the accept cycle (`irq_valid & irq_ready`) with `irq_id == i`.
- `pend[i]` update: a set event sets the bit, and a set wins over a clear in the same cycle. Otherwise a clear event clears it. Otherwise the bit holds.
- `ovf[i]` is set by a set event while `pend[i]` is 1 and no clear of i occurs that cycle. `clr_ovf` clears all bits, but a same-cycle set of `ovf[i]` wins over `clr_ovf`.
- FSM states:
  - IDLE: `irq_valid` = 0, counter = 0. If `enc_v`, capture `enc_b` into `id_q` and go to OFFER.
  - OFFER: `irq_valid` = 1 and `irq_id` = `id_q`, both held stable.
    - If `irq_ready`: clear `pend[id_q]` and go to GAP.
    - Else if `TIMEOUT` != 0 and counter == `TIMEOUT` - 1: pulse `timeout`, leave `pend` untouched, go to GAP.
    - Else increment the counter.
  - GAP: one cycle with `irq_valid` = 0, so the encoder settles on the updated `pend`. Then go to IDLE.
- No preemption: a higher-priority request arriving during OFFER waits until the next IDLE capture.
- The counter is 8 bits wide. `TIMEOUT` is limited to 0..255.

## Timing
- Reset values: `pend` = 0, `req_q` = 0, `ovf` = 0, `id_q` = 0, counter = 0, state = IDLE, `irq_valid` = 0, `irq_id` = 0, `timeout` = 0.
- `req` high before edge k: `pend` is 1 after edge k, and `irq_valid` is 1 after edge k+1. Latency is 2 cycles.
- Accept at edge m: `pend` bit is cleared and the state is GAP after m. State is IDLE after m+1. The earliest next `irq_valid` is after m+2, giving a throughput of one grant per 3 cycles.
- `irq_id` may change only while `irq_valid` = 0.
- `rst_n` asserted mid-offer forces all outputs to reset values immediately, asynchronously. Deassertion takes effect at the next edge.
- `timeout` asserts in the same cycle that the state goes to GAP.

## Configuration
- `IRQ_EDGE_EN` defined: rising-edge capture. Pending bits stay set after `req` falls. Overrun detection is active.
- `IRQ_EDGE_EN` undefined: level capture. A held `req` re-sets `pend` immediately after a clear, so the channel is re-offered. `ovf` stays constant 0.

## Structure
- Package `irq_pkg` contains:
  - `NUM_CH` = 4, `ID_W` = 2, `CNT_W` = 8.
  - State enum `irq_state_t` with values IDLE, OFFER, GAP.
- Sub-module `req_capture` holds `req_q`, `pend` and `ovf`, including the set and clear logic. The top module holds the FSM, the counter, and the external encoder connection.

## Test plan
- Edge mode, `req` = 4'b0100 for 1 cycle, `irq_ready` tied 1 → `irq_valid` 2 cycles later with `irq_id` = 2. `pend` returns to 0 one cycle after accept.
- `req` = 4'b1011 for 1 cycle, `irq_ready` = 1 → ids 3, 1, 0 offered in that order, each 3 cycles apart.
- Offer of id 1 held with `irq_ready` = 0, then `req[3]` pulses → `irq_id` stays 1 until accept. The next offer is id 3.
- `TIMEOUT` = 4, `irq_ready` = 0 → `timeout` pulses in the 4th OFFER cycle. GAP follows, then the same id is re-offered and `pend` is unchanged.
- Edge mode, `req[0]` pulses twice before accept → `ovf[0]` = 1. `clr_ovf` → `ovf` = 0.
- `rst_n` low during OFFER → `irq_valid`, `pend` and `ovf` are 0 immediately. Operation restarts cleanly after release.
